// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one toggle-handshake SPI master between CLIENTS
// requesters. A client holding its lock keeps the grant across multi-byte transfers.
//
// state  | meaning
// S_IDLE | arbitrating; issues the next byte on a hit
// S_WAIT | byte in flight, waiting for spi_ack to match spi_req
module spi_arbiter #(
    parameter int  CLIENTS = 2,
    localparam int OW      = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CLIENTS-1:0]     cl_req,
    output logic [CLIENTS-1:0]     cl_ack,
    input  logic [CLIENTS-1:0]     cl_lock,
    input  logic [CLIENTS-1:0]     cl_speed,
    input  logic [8*CLIENTS-1:0]   cl_d,
    output logic [8*CLIENTS-1:0]   cl_q,
    output logic                   spi_req,
    input  logic                   spi_ack,
    output logic                   spi_speed,
    output logic [7:0]             spi_d,
    input  logic [7:0]             spi_q,
    output logic [OW-1:0]          owner,
    output logic                   owner_valid
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t               state, state_nxt;
    logic [OW-1:0]        owner_nxt, pick;
    logic                 valid_nxt, fresh, fresh_nxt, hit;
    logic                 spi_req_nxt, spi_speed_nxt;
    logic [7:0]           spi_d_nxt;
    logic [CLIENTS-1:0]   ack_nxt, pending;
    logic [7:0]           d_arr [CLIENTS];
    logic [7:0]           q_reg [CLIENTS];
    logic [7:0]           q_nxt [CLIENTS];
    int                   start_i, cand;

    for (genvar g = 0; g < CLIENTS; g++) begin : g_unpack
        assign d_arr[g]          = cl_d[8*g +: 8];
        assign cl_q[8*g +: 8]    = q_reg[g];
    end

    assign pending = cl_req ^ cl_ack;

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        valid_nxt     = owner_valid;
        fresh_nxt     = fresh;
        spi_req_nxt   = spi_req;
        spi_speed_nxt = spi_speed;
        spi_d_nxt     = spi_d;
        ack_nxt       = cl_ack;
        q_nxt         = q_reg;
        hit           = 1'b0;
        pick          = owner;
        cand          = 0;
        // fresh marks "no grant since reset": the search then starts at client 0
        start_i       = fresh ? 0 : int'(owner) + 1;

        if (owner_valid && cl_lock[owner]) begin
            hit = pending[owner];
        end else begin
            // descending scan so the closest client to the pointer wins
            for (int k = CLIENTS - 1; k >= 0; k--) begin
                cand = start_i + k;
                if (cand >= CLIENTS) cand = cand - CLIENTS;
                if (pending[OW'(cand)]) begin
                    hit  = 1'b1;
                    pick = OW'(cand);
                end
            end
        end

        case (state)
            S_IDLE: begin
                if (hit) begin
                    owner_nxt     = pick;
                    valid_nxt     = 1'b1;
                    fresh_nxt     = 1'b0;
                    spi_d_nxt     = d_arr[pick];
                    spi_speed_nxt = cl_speed[pick];
                    spi_req_nxt   = ~spi_req;
                    state_nxt     = S_WAIT;
                end else if (!cl_lock[owner]) begin
                    valid_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                if (spi_ack == spi_req) begin
                    q_nxt[owner]   = spi_q;
                    ack_nxt[owner] = ~cl_ack[owner];
                    state_nxt      = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            owner       <= '0;
            owner_valid <= 1'b0;
            fresh       <= 1'b1;
            spi_req     <= 1'b0;
            spi_speed   <= 1'b0;
            spi_d       <= '0;
            cl_ack      <= '0;
            for (int i = 0; i < CLIENTS; i++) q_reg[i] <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            owner_valid <= valid_nxt;
            fresh       <= fresh_nxt;
            spi_req     <= spi_req_nxt;
            spi_speed   <= spi_speed_nxt;
            spi_d       <= spi_d_nxt;
            cl_ack      <= ack_nxt;
            q_reg       <= q_nxt;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Randomised bench for spi_arbiter (4 clients) against a transaction-level
// round-robin reference model; includes lock phases and a reset during a transfer.
module tb_spi_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  cl_req, cl_lock, cl_speed;
    logic [N-1:0]  cl_ack;
    logic [8*N-1:0] cl_d;
    logic [8*N-1:0] cl_q;
    logic          spi_req, spi_ack, spi_speed;
    logic [7:0]    spi_d, spi_q;
    logic [1:0]    owner;
    logic          owner_valid;

    spi_arbiter #(.CLIENTS(N)) dut (
        .clk(clk), .reset(reset),
        .cl_req(cl_req), .cl_ack(cl_ack), .cl_lock(cl_lock), .cl_speed(cl_speed),
        .cl_d(cl_d), .cl_q(cl_q),
        .spi_req(spi_req), .spi_ack(spi_ack), .spi_speed(spi_speed),
        .spi_d(spi_d), .spi_q(spi_q),
        .owner(owner), .owner_valid(owner_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [N-1:0] mack;
    logic [7:0]   mq [N];
    int           mowner;
    bit           mvalid, mfresh, mbusy, mspi_req, mspeed;
    logic [7:0]   md;

    // SPI master environment
    bit           spi_busy;
    int           spi_cnt;

    int           req_pct;
    bit           lock_on;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mack = '0;
        for (int i = 0; i < N; i++) mq[i] = 8'h00;
        mowner = 0; mvalid = 0; mfresh = 1; mbusy = 0;
        mspi_req = 0; mspeed = 0; md = 8'h00;
    endtask

    // distance-ordered round-robin choice; -1 when nobody is eligible
    function automatic int rr_pick(input logic [N-1:0] pend);
        int c;
        if (mvalid && cl_lock[mowner]) return pend[mowner] ? mowner : -1;
        for (int d = 0; d < N; d++) begin
            c = mfresh ? d : (mowner + 1 + d) % N;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int c;
        if (mbusy) begin
            if (spi_ack == mspi_req) begin
                mack[mowner] = ~mack[mowner];
                mq[mowner]   = spi_q;
                mbusy        = 0;
            end
        end else begin
            c = rr_pick(cl_req ^ mack);
            if (c >= 0) begin
                mowner   = c;
                mvalid   = 1;
                mfresh   = 0;
                mbusy    = 1;
                mspi_req = ~mspi_req;
                md       = cl_d[c*8 +: 8];
                mspeed   = cl_speed[c];
            end else if (!cl_lock[mowner]) begin
                mvalid = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("cl_ack",      32'(cl_ack),      32'(mack));
        chk("owner",       32'(owner),       32'(mowner));
        chk("owner_valid", 32'(owner_valid), 32'(mvalid));
        chk("spi_req",     32'(spi_req),     32'(mspi_req));
        chk("spi_d",       32'(spi_d),       32'(md));
        chk("spi_speed",   32'(spi_speed),   32'(mspeed));
        chk("cl_q",        cl_q,             {mq[3], mq[2], mq[1], mq[0]});
    endtask

    task automatic drive_clients();
        for (int i = 0; i < N; i++) begin
            if (cl_req[i] == mack[i]) begin
                cl_d[i*8 +: 8] = 8'($urandom);
                cl_speed[i]    = 1'($urandom);
                if ($urandom_range(0, 99) < req_pct) cl_req[i] = ~cl_req[i];
            end
            if (!lock_on) cl_lock[i] = 1'b0;
            else if ($urandom_range(0, 15) == 0) cl_lock[i] = ~cl_lock[i];
        end
    endtask

    task automatic spi_model();
        if (spi_req != spi_ack) begin
            if (!spi_busy) begin
                spi_busy = 1;
                spi_cnt  = $urandom_range(0, 4);
            end
            if (spi_cnt == 0) begin
                spi_ack  = spi_req;
                spi_q    = 8'($urandom);
                spi_busy = 0;
            end else begin
                spi_cnt--;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive_clients();
        spi_model();
        @(posedge clk);
        model_edge();
        #1 compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        cl_req   = '0;
        cl_lock  = '0;
        spi_ack  = 1'b0;
        spi_busy = 0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        bit did_rst;
        reset    = 1'b1;
        cl_req   = '0;
        cl_lock  = '0;
        cl_speed = '0;
        cl_d     = '0;
        spi_ack  = 1'b0;
        spi_q    = 8'h00;
        spi_busy = 0;
        spi_cnt  = 0;
        req_pct  = 30;
        lock_on  = 0;
        did_rst  = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        for (int cyc = 0; cyc < 500; cyc++) step();

        lock_on = 1;
        req_pct = 40;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!did_rst && cyc >= 700 && mbusy) begin
                do_reset();
                did_rst = 1;
            end
            step();
        end
        chk("reset_mid_wait_done", 32'(did_rst), 32'd1);

        lock_on = 0;
        req_pct = 85;
        for (int cyc = 0; cyc < 600; cyc++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
